wb_arbiter_2m: RTL
==================

// Module: wb_arbiter_2m
// PURPOSE
// Two-master, one-slave Wishbone B3 arbiter. Shares the system Wishbone bus between the
//   core port (M0) and a second master such as DMA or debug (M1).
// Round-robin grant, held for the whole cyc tenure (locked bursts). Per-transfer ack
//   timeout returns err so a dead slave cannot hang a master.
// PARAMETERS
// WB_DWIDTH  32   data bus width; address fixed at 32 bits
// WB_SWIDTH  4    byte-select width (WB_DWIDTH/8)
// TIMEOUT    255  stalled stb cycles before forced err; 8-bit counter; legal range 2..255
// PORTS
// i_clk          in   1          system clock; all state on posedge
// i_rst          in   1          synchronous reset, active-high
// i_m{0,1}_wb_adr in  32         master address
// i_m{0,1}_wb_sel in  WB_SWIDTH  master byte selects
// i_m{0,1}_wb_we  in  1          master write enable
// i_m{0,1}_wb_dat in  WB_DWIDTH  master write data
// i_m{0,1}_wb_cyc in  1          master cycle request; held high = locked tenure
// i_m{0,1}_wb_stb in  1          master strobe
// o_m{0,1}_wb_dat out WB_DWIDTH  read data; i_wb_dat to both masters
// o_m{0,1}_wb_ack out 1          ack to granted master only
// o_m{0,1}_wb_err out 1          err to granted master only; slave err or timeout
// o_wb_adr       out  32         slave address
// o_wb_sel       out  WB_SWIDTH  slave byte selects
// o_wb_we        out  1          slave write enable
// o_wb_dat       out  WB_DWIDTH  slave write data
// o_wb_cyc       out  1          slave cycle
// o_wb_stb       out  1          slave strobe
// i_wb_dat       in   WB_DWIDTH  slave read data
// i_wb_ack       in   1          slave ack
// i_wb_err       in   1          slave err
// o_grant        out  2          one-hot grant register; 01=M0, 10=M1, 00=idle
// BEHAVIOUR
// - FSM {IDLE, GNT_M0, GNT_M1}; o_grant is the registered state. last_gnt register.
// - Reset: state IDLE, o_grant=00, last_gnt=M1 so M0 wins first.
//   All o_wb_* = 0; all o_mX_wb_ack/err = 0; timeout counter = 0.
// - IDLE, one master with cyc=1: grant it next cycle.
//   IDLE, both with cyc=1: grant the master != last_gnt; last_gnt updates on grant.
// - Latency: request in IDLE -> o_wb_cyc high 1 cycle later.
// - GNT_Mx: o_wb_adr/sel/we/dat/cyc/stb are combinational copies of Mx. In IDLE they are all 0.
// - GNT_Mx: o_mx_wb_ack = i_wb_ack & i_mx_wb_stb, combinational, same cycle.
//   The other master's ack/err stay 0.
// - Grant is held while i_mx_wb_cyc=1, across any number of beats.
//   i_mx_wb_cyc=0 -> IDLE next cycle. One dead cycle always separates tenures.
// - Same-cycle i_wb_ack and i_wb_err: err forwarded, ack suppressed.
// - Timeout counter increments on each cycle with o_wb_cyc & o_wb_stb & ~i_wb_ack & ~i_wb_err.
//   It clears on ack, err, stb low, or leaving GNT_Mx.
// - Counter reaching TIMEOUT-1 while still stalled: o_mx_wb_err pulses for 1 cycle on that
//   TIMEOUT-th stalled cycle, and the counter clears. Bus signals stay driven by the master.
// - Counter saturation: it cannot exceed TIMEOUT-1.
// - Ack/err from the slave while state is IDLE: dropped.
// - i_rst mid-tenure: IDLE next cycle. Outputs take their reset values, and any in-flight
//   ack is not forwarded after reset. Reset has priority over all events.
// TESTING
// - Reset: i_rst=1 for 2 cycles with both cyc=1 -> o_wb_cyc=0, o_grant=00.
//   Release -> o_grant=01 one cycle later.
// - M1 read only: adr=0x0000_1000, we=0; slave acks 2 cycles later with i_wb_dat=0xDEADBEEF.
//   -> o_m1_wb_ack=1 and o_m1_wb_dat=0xDEADBEEF in that cycle; o_m0_wb_ack stays 0.
// - Contention: both masters issue single-beat cycles, cyc dropped after each ack.
//   -> o_grant sequence 01,00,10,00,01.
// - Locked burst: M0 holds cyc for 4 acked beats while M1 requests.
//   -> o_grant stays 01 for all 4 beats, then 00 for one cycle, then 10.
// - Timeout=8: M0 stb with slave never acking -> o_m0_wb_err=1 on exactly the 8th stalled
//   cycle, for one cycle, then re-arms.
// - Error and reset: ack and err same cycle -> err=1, ack=0.
//   i_rst asserted mid-stall -> o_wb_cyc=0, o_grant=00 next cycle.

Source files
------------

// File: rtl/wb_arbiter_2m_if.sv
// Wishbone B3 point-to-point bundle shared by the arbiter's master and slave sides.
interface wb_arbiter_2m_if #(
  parameter int WB_DWIDTH = 32,
  parameter int WB_SWIDTH = WB_DWIDTH / 8
);
  logic [31:0]          adr;
  logic [WB_SWIDTH-1:0] sel;
  logic                 we;
  logic [WB_DWIDTH-1:0] dat_w;
  logic [WB_DWIDTH-1:0] dat_r;
  logic                 cyc;
  logic                 stb;
  logic                 ack;
  logic                 err;

  modport master (
    output adr, sel, we, dat_w, cyc, stb,
    input  dat_r, ack, err
  );

  modport slave (
    input  adr, sel, we, dat_w, cyc, stb,
    output dat_r, ack, err
  );
endinterface

// File: rtl/wb_arbiter_2m.sv
// Two-master / one-slave Wishbone B3 arbiter: round-robin grant locked for the whole
// cyc tenure, with a per-transfer ack timeout that answers a stalled strobe with err.
module wb_arbiter_2m #(
  parameter int WB_DWIDTH = 32,
  parameter int WB_SWIDTH = WB_DWIDTH / 8,
  parameter int TIMEOUT   = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  wb_arbiter_2m_if.slave        m0,
  wb_arbiter_2m_if.slave        m1,
  wb_arbiter_2m_if.master       wbs,
  output logic [1:0]            grant
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GNT_M0 = 2'b01,
    GNT_M1 = 2'b10
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t               state_r, state_nxt_s;
  logic                 last_m1_r, last_m1_nxt_s;
  logic [7:0]           tmo_cnt_r, tmo_cnt_nxt_s;

  logic                 sel_m0_s, sel_m1_s;
  logic [31:0]          adr_s;
  logic [WB_SWIDTH-1:0] bsel_s;
  logic                 we_s;
  logic [WB_DWIDTH-1:0] dat_w_s;
  logic                 cyc_s, stb_s;
  logic                 stall_s, tmo_hit_s, ack_s, err_s;

  // Reset masks the grant immediately so nothing is forwarded during the reset cycle.
  assign sel_m0_s = (state_r == GNT_M0) & ~rst;
  assign sel_m1_s = (state_r == GNT_M1) & ~rst;

  // Slave-side bus mux: copy of the granted master, all zero when idle.
  always_comb begin
    adr_s   = 32'h0000_0000;
    bsel_s  = {WB_SWIDTH{1'b0}};
    we_s    = 1'b0;
    dat_w_s = {WB_DWIDTH{1'b0}};
    cyc_s   = 1'b0;
    stb_s   = 1'b0;
    if (sel_m0_s) begin
      adr_s   = m0.adr;
      bsel_s  = m0.sel;
      we_s    = m0.we;
      dat_w_s = m0.dat_w;
      cyc_s   = m0.cyc;
      stb_s   = m0.stb;
    end else if (sel_m1_s) begin
      adr_s   = m1.adr;
      bsel_s  = m1.sel;
      we_s    = m1.we;
      dat_w_s = m1.dat_w;
      cyc_s   = m1.cyc;
      stb_s   = m1.stb;
    end else begin
      cyc_s   = 1'b0;
    end
  end

  assign wbs.adr   = adr_s;
  assign wbs.sel   = bsel_s;
  assign wbs.we    = we_s;
  assign wbs.dat_w = dat_w_s;
  assign wbs.cyc   = cyc_s;
  assign wbs.stb   = stb_s;

  assign m0.dat_r  = wbs.dat_r;
  assign m1.dat_r  = wbs.dat_r;

  // cyc_s/stb_s are already zero when idle, so slave responses in IDLE vanish here.
  assign stall_s   = cyc_s & stb_s & ~wbs.ack & ~wbs.err;
  assign tmo_hit_s = stall_s & (tmo_cnt_r == TMO_LAST);
  assign ack_s     = cyc_s & stb_s & wbs.ack & ~wbs.err;
  assign err_s     = (cyc_s & stb_s & wbs.err) | tmo_hit_s;

  assign m0.ack = sel_m0_s & ack_s;
  assign m0.err = sel_m0_s & err_s;
  assign m1.ack = sel_m1_s & ack_s;
  assign m1.err = sel_m1_s & err_s;

  assign grant = state_r;

  // Next-state, round-robin pointer and timeout counter.
  always_comb begin
    state_nxt_s   = state_r;
    last_m1_nxt_s = last_m1_r;
    case (state_r)
      IDLE: begin
        if (m0.cyc && (!m1.cyc || last_m1_r)) begin
          state_nxt_s   = GNT_M0;
          last_m1_nxt_s = 1'b0;
        end else if (m1.cyc) begin
          state_nxt_s   = GNT_M1;
          last_m1_nxt_s = 1'b1;
        end else begin
          state_nxt_s   = IDLE;
        end
      end
      GNT_M0: begin
        if (!m0.cyc) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = GNT_M0;
        end
      end
      GNT_M1: begin
        if (!m1.cyc) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = GNT_M1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase

    // Clearing on the hit keeps the count at or below TMO_LAST.
    if (stall_s && !tmo_hit_s) begin
      tmo_cnt_nxt_s = tmo_cnt_r + 8'd1;
    end else begin
      tmo_cnt_nxt_s = 8'd0;
    end
  end

  // State registers; last_m1 resets high so M0 wins the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      last_m1_r <= 1'b1;
      tmo_cnt_r <= 8'd0;
    end else begin
      state_r   <= state_nxt_s;
      last_m1_r <= last_m1_nxt_s;
      tmo_cnt_r <= tmo_cnt_nxt_s;
    end
  end

endmodule
